systolic_tile_sequencer: RTL
============================

// Module: systolic_tile_sequencer
// PURPOSE
//  Front/back end for two_by_two_systolic. Accepts a byte stream (filter 3x3, then input tile 4x4)
//  over valid/ready, drives the array's parallel tile/filter inputs and its active-high rst.
//  Lets the array run a fixed number of cycles, captures the 2x2 result and streams it out
//  as 4 bytes over valid/ready. One tile in flight; back-to-back tiles loop forever.
// PARAMETERS
//  DATA_W      8   width of every stream byte, tile, filter and output element
//  RUN_CYCLES  50  cycles the array runs out of reset before o_flat is sampled (legal >= 1)
// PORTS
//  clk      in   1          clock; all state on rising edge
//  rst      in   1          asynchronous, active-low reset
//  s_valid  in   1          input byte valid
//  s_ready  out  1          input byte ready
//  s_data   in   DATA_W     input byte
//  arr_rst  out  1          to array rst (active-high); 1 = array held in reset
//  f_flat   out  9*DATA_W   filter to array; f_flat[DATA_W*k +: DATA_W], k=r*3+c (k=0 is f00)
//  i_flat   out  16*DATA_W  tile to array; k=r*4+c (k=0 is i00)
//  o_flat   in   4*DATA_W   array result; k=r*2+c (o00,o01,o10,o11)
//  m_valid  out  1          output byte valid
//  m_ready  in   1          output byte ready
//  m_data   out  DATA_W     output byte
//  m_last   out  1          high with the 4th output byte (o11)
//  busy     out  1          high outside the LOAD states
// BEHAVIOUR
//  Reset (rst=0, async): state LOAD_F, byte count 0, f/i regs 0, out regs 0, arr_rst=1,
//   m_valid=0, m_data=0, m_last=0, busy=0. s_ready is 1 when state is LOAD_F/LOAD_I.
//  States: LOAD_F -> LOAD_I -> RUN -> CAPTURE -> DRAIN -> LOAD_F.
//  LOAD_F: s_ready=1. Each s_valid&s_ready writes f[k], k=0..8. Accepting k=8 -> LOAD_I.
//  LOAD_I: s_ready=1. Bytes fill i[k], k=0..15. Accepting k=15 -> RUN.
//  s_valid low: count holds, no write. arr_rst=1 during both LOAD states.
//  RUN: arr_rst=0, s_ready=0. Stay exactly RUN_CYCLES cycles (down-counter), then CAPTURE.
//  CAPTURE (1 cycle): arr_rst=0. Register o_flat at the closing edge -> DRAIN.
//  Latency: last input byte accepted at edge E. m_valid first high after edge E+RUN_CYCLES+1.
//  DRAIN: arr_rst=1, m_valid=1, m_data=o00,o01,o10,o11 in order, m_last=1 only with o11.
//   Advance only on m_valid&m_ready. While m_ready=0, m_data/m_last are held stable.
//   Accepting o11 -> LOAD_F the next cycle: m_valid=0, count 0. f/i regs keep old values
//   until overwritten.
//  s_valid during RUN/CAPTURE/DRAIN: ignored (s_ready=0), no byte consumed.
//  f_flat/i_flat change only on accepted load bytes, so they are stable during RUN.
//  Reset mid-operation (any state): immediate return to reset values. Partial tile discarded.
//   No output byte emitted.
//  No arithmetic beyond counters. Byte counter 5 bits. RUN counter $clog2(RUN_CYCLES+1) bits.
// STRUCTURE
//  Shared header systolic_defs.vh: DATA_W, IN_DIM=4, F_DIM=3, OUT_DIM=2, element counts
//   (16/9/4), state encodings. It is also used by two_by_two_systolic.
//  One sub-module, result_serializer: 4xDATA_W parallel load -> valid/ready byte stream with last.
//  The FSM, load registers and RUN counter stay in this module.
// TESTING  (bench pairs the DUT with two_by_two_systolic, or a behavioural 3x3 valid-conv model)
//  1 Stream f=3,2,0,2,0,1,3,1,1 then i=9,8,2,6,0,4,1,6,4,10,1,1,2,2,9,9, m_ready=1.
//    -> m_data 67,74,34,59, m_last with 59. m_valid rises RUN_CYCLES+1 edges after the last accept.
//  2 Same stimulus, s_valid toggled randomly.
//    -> identical outputs. f_flat/i_flat match the bytes. s_ready=0 throughout RUN.
//  3 Hold m_ready=0 for 7 cycles in DRAIN, then release.
//    -> m_data=67 held stable, then 74,34,59. No byte lost or duplicated.
//  4 Drive s_valid=1 with byte 0xFF during RUN and DRAIN.
//    -> not accepted. Next tile's f00 is the first byte offered after LOAD_F.
//  5 Assert rst after 12 loaded bytes, then reload the full tile.
//    -> arr_rst=1, m_valid=0 during reset. Result equals scenario 1.
//  6 Two tiles back to back (second: all ones input, all ones filter).
//    -> 67,74,34,59 then 9,9,9,9. arr_rst=1 between tiles.

Source files
------------

// File: rtl/systolic_tile_sequencer_pkg.sv
// Shared definitions for the systolic tile sequencer and its result serializer.
// Holds the tile geometry, element counts, counter widths and the sequencer
// state encoding so that every file agrees on them.
package systolic_tile_sequencer_pkg;

    localparam int IN_DIM  = 4;                 // input tile is IN_DIM x IN_DIM
    localparam int F_DIM   = 3;                 // filter is F_DIM x F_DIM
    localparam int OUT_DIM = 2;                 // result is OUT_DIM x OUT_DIM
    localparam int IN_N    = IN_DIM * IN_DIM;   // 16 tile elements
    localparam int F_N     = F_DIM * F_DIM;     // 9 filter elements
    localparam int OUT_N   = OUT_DIM * OUT_DIM; // 4 result elements
    localparam int CNT_W   = 5;                 // byte counter width (covers 0..15)

    typedef enum logic [2:0] {
        ST_LOAD_F  = 3'd0,
        ST_LOAD_I  = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    function automatic logic is_load(input state_t s);
        return (s == ST_LOAD_F) || (s == ST_LOAD_I);
    endfunction

endpackage

// File: rtl/systolic_tile_sequencer_result_serializer.sv
// result_serializer: captures OUT_N parallel elements in one cycle and streams
// them out one per handshake, element 0 first, with m_last on the final one.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   load, load_data     parallel load strobe and OUT_N*DATA_W data (k=0 first out)
//   m_valid/m_ready     output byte handshake
//   m_data, m_last      current element, high on the final element
//   done                final element accepted this cycle
module result_serializer
    import systolic_tile_sequencer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [OUT_N*DATA_W-1:0] load_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_last,
    output logic                    done
);

    localparam int IDX_W = $clog2(OUT_N);

    logic [DATA_W-1:0] elem [OUT_N];
    logic [IDX_W-1:0]  idx;
    logic              valid_q;

    // Output is driven straight from the held registers, so m_data/m_last stay
    // stable for as long as the consumer stalls.
    assign m_valid = valid_q;
    assign m_data  = elem[idx];
    assign m_last  = valid_q && (idx == IDX_W'(OUT_N - 1));
    assign done    = valid_q && m_ready && m_last;

    // NOTE: the element registers are reset along with the control state so that
    // m_data reads 0 out of reset; they are few enough to be plain flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < OUT_N; k++) elem[k] <= '0;
            idx     <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            for (int k = 0; k < OUT_N; k++) elem[k] <= load_data[DATA_W*k +: DATA_W];
            idx     <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && m_ready) begin
            // Index wraps back to 0 after the last element.
            idx <= idx + 1'b1;
            if (m_last) valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer: front/back end for a 2x2 systolic convolution array.
// Loads a 3x3 filter then a 4x4 tile from a byte stream, releases the array
// from reset for RUN_CYCLES cycles plus one capture cycle, then streams the
// 2x2 result out as four bytes.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   s_valid/s_ready/s_data   input byte stream (filter bytes, then tile bytes)
//   arr_rst                  active-high reset to the array
//   f_flat, i_flat           filter / tile to the array, element k at [DATA_W*k +: DATA_W]
//   o_flat                   array result, o00,o01,o10,o11 at k=0..3
//   m_valid/m_ready/m_data   output byte stream, m_last with o11
//   busy                     high outside the load states
module systolic_tile_sequencer
    import systolic_tile_sequencer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int RUN_CYCLES = 50
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    output logic                    arr_rst,
    output logic [F_N*DATA_W-1:0]   f_flat,
    output logic [IN_N*DATA_W-1:0]  i_flat,
    input  logic [OUT_N*DATA_W-1:0] o_flat,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_last,
    output logic                    busy
);

    localparam int RUN_W = $clog2(RUN_CYCLES + 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [RUN_W-1:0]  run_cnt;
    logic [DATA_W-1:0] f_regs [F_N];
    logic [DATA_W-1:0] i_regs [IN_N];
    logic              accept;
    logic              last_f, last_i;
    logic              ser_done;

    assign s_ready = is_load(state);
    assign busy    = !is_load(state);
    assign arr_rst = !((state == ST_RUN) || (state == ST_CAPTURE));
    assign accept  = s_valid && s_ready;
    assign last_f  = (byte_cnt == CNT_W'(F_N - 1));
    assign last_i  = (byte_cnt == CNT_W'(IN_N - 1));

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_LOAD_F:  if (accept && last_f) state_nxt = ST_LOAD_I;
            ST_LOAD_I:  if (accept && last_i) state_nxt = ST_RUN;
            ST_RUN:     if (run_cnt == RUN_W'(1)) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_DRAIN;
            ST_DRAIN:   if (ser_done) state_nxt = ST_LOAD_F;
            default:    state_nxt = ST_LOAD_F;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_LOAD_F;
            byte_cnt <= '0;
            run_cnt  <= '0;
        end else begin
            state <= state_nxt;
            // The byte counter is shared by both load phases: it wraps to 0
            // on the last filter byte and again on the last tile byte.
            if (accept) byte_cnt <= (last_f && state == ST_LOAD_F) || last_i ? '0 : byte_cnt + 1'b1;
            // Loaded with the last tile byte, so RUN lasts exactly RUN_CYCLES cycles.
            if (state == ST_LOAD_I && accept && last_i) run_cnt <= RUN_W'(RUN_CYCLES);
            else if (state == ST_RUN)                   run_cnt <= run_cnt - 1'b1;
        end
    end

    // Filter/tile registers change only on accepted load bytes, so the array
    // sees stable operands for the whole run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < F_N; k++)  f_regs[k] <= '0;
            for (int k = 0; k < IN_N; k++) i_regs[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < F_N; k++)
                if (state == ST_LOAD_F && byte_cnt == CNT_W'(k)) f_regs[k] <= s_data;
            for (int k = 0; k < IN_N; k++)
                if (state == ST_LOAD_I && byte_cnt == CNT_W'(k)) i_regs[k] <= s_data;
        end
    end

    always_comb begin
        f_flat = '0;
        i_flat = '0;
        for (int k = 0; k < F_N; k++)  f_flat[DATA_W*k +: DATA_W] = f_regs[k];
        for (int k = 0; k < IN_N; k++) i_flat[DATA_W*k +: DATA_W] = i_regs[k];
    end

    result_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (state == ST_CAPTURE),
        .load_data (o_flat),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .done      (ser_done)
    );

endmodule
